// File: rtl/serial_pattern_transmitter_pkg.sv
// serial_tx_pkg: shared defaults and FSM state type for the serial pattern transmitter
package serial_tx_pkg;
    localparam int MAX_LEN_DEF = 8;
    localparam int REP_W_DEF   = 4;
    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
endpackage

// File: rtl/serial_pattern_transmitter_if.sv
// serial_pattern_transmitter_if: pattern handshake and serial output bundle
interface serial_pattern_transmitter_if #(
    parameter int MAX_LEN = serial_tx_pkg::MAX_LEN_DEF,
    parameter int REP_W   = serial_tx_pkg::REP_W_DEF
);
    localparam int LEN_W = $clog2(MAX_LEN) + 1;
    logic               pat_valid;
    logic               pat_ready;
    logic [MAX_LEN-1:0] pat_data;
    logic [LEN_W-1:0]   pat_len;
    logic [REP_W-1:0]   pat_repeat;
    logic               abort;
    logic               out_bit;
    logic               out_valid;
    logic               done;
    modport master (
        output pat_valid, pat_data, pat_len, pat_repeat, abort,
        input  pat_ready, out_bit, out_valid, done
    );
    modport slave (
        input  pat_valid, pat_data, pat_len, pat_repeat, abort,
        output pat_ready, out_bit, out_valid, done
    );
endinterface

// File: rtl/serial_pattern_transmitter_shift_out.sv
// serial_shift_out: MSB-first pattern shifter with bit index and pass-boundary reload
module serial_shift_out #(
    parameter int MAX_LEN = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             load,
    input  logic                             shift,
    input  logic                             clear,
    input  logic [MAX_LEN-1:0]               data,
    input  logic [$clog2(MAX_LEN):0]         len,
    output logic                             bit_out,
    output logic                             last_bit
);
    localparam int LEN_W = $clog2(MAX_LEN) + 1;
    logic [MAX_LEN-1:0] pat;
    logic [MAX_LEN-1:0] sr;
    logic [MAX_LEN-1:0] aligned;
    logic [LEN_W-1:0]   idx;
    logic [LEN_W-1:0]   len_r;
    // left-align the pattern so its first bit sits in the MSB; unused high bits fall off
    always_comb aligned = data << (LEN_W'(MAX_LEN) - len);
    assign bit_out  = sr[MAX_LEN-1];
    assign last_bit = idx == len_r - LEN_W'(1);
    // shift one bit per cycle, reloading the held pattern at each pass boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat   <= '0;
            sr    <= '0;
            idx   <= '0;
            len_r <= '0;
        end else if (clear) begin
            sr  <= '0;
            idx <= '0;
        end else if (load) begin
            pat   <= aligned;
            sr    <= aligned;
            len_r <= len;
            idx   <= '0;
        end else if (shift) begin
            sr  <= last_bit ? pat : sr << 1;
            idx <= last_bit ? '0 : idx + LEN_W'(1);
        end
    end
endmodule

// File: rtl/serial_pattern_transmitter.sv
// serial_pattern_transmitter: accepts a parallel pattern and serializes it MSB-first with repeats
module serial_pattern_transmitter
    import serial_tx_pkg::*;
#(
    parameter int MAX_LEN = MAX_LEN_DEF,
    parameter int REP_W   = REP_W_DEF
) (
    input logic clk,
    input logic rst_n,
    serial_pattern_transmitter_if.slave bus
);
    localparam int LEN_W = $clog2(MAX_LEN) + 1;
    state_t           state, state_n;
    logic [REP_W-1:0] pass_cnt;
    logic [LEN_W-1:0] len_c;
    logic             load, shift, clear, last_bit, bit_out;
    logic             ready_r, valid_r, done_r;
    assign len_c = bus.pat_len > LEN_W'(MAX_LEN) ? LEN_W'(MAX_LEN) : bus.pat_len;
    serial_shift_out #(.MAX_LEN(MAX_LEN)) u_shift (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .shift    (shift),
        .clear    (clear),
        .data     (bus.pat_data),
        .len      (len_c),
        .bit_out  (bit_out),
        .last_bit (last_bit)
    );
    // next state and shifter controls; a zero-length pattern skips straight to DONE
    always_comb begin
        state_n = state;
        load    = 1'b0;
        shift   = 1'b0;
        clear   = 1'b0;
        case (state)
            IDLE: begin
                state_n = bus.pat_valid ? (len_c == '0 ? DONE : SEND) : IDLE;
                load    = bus.pat_valid && len_c != '0;
            end
            SEND: begin
                clear   = bus.abort || (last_bit && pass_cnt == '0);
                shift   = !clear;
                state_n = bus.abort ? IDLE : (clear ? DONE : SEND);
            end
            default: state_n = IDLE;
        endcase
    end
    // state, pass counter and registered handshake/status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pass_cnt <= '0;
            ready_r  <= 1'b1;
            valid_r  <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state    <= state_n;
            pass_cnt <= load ? bus.pat_repeat : clear ? '0 : (shift && last_bit) ? pass_cnt - REP_W'(1) : pass_cnt;
            ready_r  <= state_n == IDLE;
            valid_r  <= state_n == SEND;
            done_r   <= state_n == DONE;
        end
    end
    assign bus.pat_ready = ready_r;
    assign bus.out_valid = valid_r;
    assign bus.done      = done_r;
    assign bus.out_bit   = bit_out;
endmodule

// File: tb/tb_serial_pattern_transmitter.sv
// tb_serial_pattern_transmitter: directed checks of serialization, repeats, abort and reset
module tb_serial_pattern_transmitter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic vb [0:23];
    logic ob [0:23];
    logic db [0:23];
    logic rb [0:23];

    serial_pattern_transmitter_if bus ();

    serial_pattern_transmitter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // offer one pattern for a single cycle, then record n cycles of outputs (index 0 = first cycle after accept)
    task automatic offer_capture(input logic [7:0] data, input logic [3:0] len, input logic [3:0] rep, input int n);
        @(negedge clk);
        bus.pat_data   = data;
        bus.pat_len    = len;
        bus.pat_repeat = rep;
        bus.pat_valid  = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            vb[i] = bus.out_valid;
            ob[i] = bus.out_bit;
            db[i] = bus.done;
            rb[i] = bus.pat_ready;
            bus.pat_valid = 1'b0;
        end
    endtask

    task automatic test_reset;
        #12;
        checks++; if (bus.pat_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", bus.pat_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        checks++; if (bus.out_bit !== 1'b0) begin errors++; $display("FAIL reset_out_bit got %b want 0", bus.out_bit); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        logic [5:0] exp;
        logic [5:0] win;
        int det;
        exp = 6'b110011;
        win = '0;
        det = 0;
        offer_capture(8'b1111_0011 & 8'h3F | 8'h00, 4'd6, 4'd0, 9);
        for (int k = 0; k < 6; k++) begin
            checks++; if (vb[k] !== 1'b1 || ob[k] !== exp[5-k]) begin errors++; $display("FAIL basic_bit%0d got v=%b b=%b want v=1 b=%b", k, vb[k], ob[k], exp[5-k]); end
            checks++; if (db[k] !== 1'b0) begin errors++; $display("FAIL basic_early_done%0d got %b want 0", k, db[k]); end
        end
        checks++; if (db[6] !== 1'b1 || vb[6] !== 1'b0 || ob[6] !== 1'b0) begin errors++; $display("FAIL basic_done got d=%b v=%b b=%b want d=1 v=0 b=0", db[6], vb[6], ob[6]); end
        checks++; if (rb[0] !== 1'b0 || rb[6] !== 1'b0 || rb[7] !== 1'b1) begin errors++; $display("FAIL basic_ready got %b%b%b want 001", rb[0], rb[6], rb[7]); end
        for (int i = 0; i < 9; i++) if (vb[i]) begin win = {win[4:0], ob[i]}; if (win == 6'b110011) det++; end
        checks++; if (det != 1) begin errors++; $display("FAIL basic_detect got %0d want 1", det); end
    endtask

    task automatic test_repeat;
        logic [11:0] exp;
        logic [3:0] win;
        int det;
        exp = 12'b1010_1010_1010;
        win = '0;
        det = 0;
        offer_capture(8'b0000_1010, 4'd4, 4'd2, 14);
        for (int k = 0; k < 12; k++) begin
            checks++; if (vb[k] !== 1'b1 || ob[k] !== exp[11-k]) begin errors++; $display("FAIL repeat_bit%0d got v=%b b=%b want v=1 b=%b", k, vb[k], ob[k], exp[11-k]); end
        end
        checks++; if (db[12] !== 1'b1 || vb[12] !== 1'b0 || db[11] !== 1'b0) begin errors++; $display("FAIL repeat_done got d12=%b v12=%b d11=%b want 1 0 0", db[12], vb[12], db[11]); end
        for (int i = 0; i < 14; i++) if (vb[i]) begin win = {win[2:0], ob[i]}; if (win == 4'b1010) det++; end
        checks++; if (det != 5) begin errors++; $display("FAIL repeat_detect got %0d want 5", det); end
    endtask

    task automatic test_len0;
        int vcnt;
        vcnt = 0;
        offer_capture(8'hFF, 4'd0, 4'd5, 4);
        checks++; if (db[0] !== 1'b1 || rb[0] !== 1'b0) begin errors++; $display("FAIL len0_done got d=%b r=%b want d=1 r=0", db[0], rb[0]); end
        checks++; if (db[1] !== 1'b0 || rb[1] !== 1'b1) begin errors++; $display("FAIL len0_idle got d=%b r=%b want d=0 r=1", db[1], rb[1]); end
        for (int i = 0; i < 4; i++) if (vb[i] !== 1'b0) vcnt++;
        checks++; if (vcnt != 0) begin errors++; $display("FAIL len0_valid got %0d valid cycles want 0", vcnt); end
    endtask

    task automatic test_clamp;
        logic [7:0] exp;
        logic [2:0] exp3;
        exp = 8'hA5;
        exp3 = 3'b110;
        offer_capture(8'hA5, 4'd15, 4'd0, 10);
        for (int k = 0; k < 8; k++) begin
            checks++; if (vb[k] !== 1'b1 || ob[k] !== exp[7-k]) begin errors++; $display("FAIL clamp_bit%0d got v=%b b=%b want v=1 b=%b", k, vb[k], ob[k], exp[7-k]); end
        end
        checks++; if (db[8] !== 1'b1 || vb[8] !== 1'b0) begin errors++; $display("FAIL clamp_done got d=%b v=%b want d=1 v=0", db[8], vb[8]); end
        offer_capture(8'b1111_0110, 4'd3, 4'd0, 5);
        for (int k = 0; k < 3; k++) begin
            checks++; if (vb[k] !== 1'b1 || ob[k] !== exp3[2-k]) begin errors++; $display("FAIL highbits_bit%0d got v=%b b=%b want v=1 b=%b", k, vb[k], ob[k], exp3[2-k]); end
        end
        checks++; if (db[3] !== 1'b1 || vb[3] !== 1'b0) begin errors++; $display("FAIL highbits_done got d=%b v=%b want d=1 v=0", db[3], vb[3]); end
    endtask

    task automatic test_abort;
        logic [2:0] exp3;
        int dseen;
        exp3 = 3'b101;
        dseen = 0;
        @(negedge clk);
        bus.pat_data = 8'hFF; bus.pat_len = 4'd8; bus.pat_repeat = 4'd0; bus.pat_valid = 1'b1;
        @(negedge clk);
        bus.pat_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL abort_pre got %b want 1", bus.out_valid); end
        bus.abort = 1'b1;
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0 || bus.pat_ready !== 1'b1 || bus.done !== 1'b0 || bus.out_bit !== 1'b0) begin errors++; $display("FAIL abort_stop got v=%b r=%b d=%b b=%b want 0 1 0 0", bus.out_valid, bus.pat_ready, bus.done, bus.out_bit); end
        bus.abort = 1'b0;
        bus.pat_data = 8'b0000_0101; bus.pat_len = 4'd3; bus.pat_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus.pat_valid = 1'b0;
            if (k < 3) begin
                checks++; if (bus.out_valid !== 1'b1 || bus.out_bit !== exp3[2-k] || bus.done !== 1'b0) begin errors++; $display("FAIL abort_next_bit%0d got v=%b b=%b d=%b want 1 %b 0", k, bus.out_valid, bus.out_bit, bus.done, exp3[2-k]); end
            end else begin
                checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL abort_next_done got %b want 1", bus.done); end
            end
        end
        @(negedge clk);
        bus.abort = 1'b1; bus.pat_data = 8'b0000_0010; bus.pat_len = 4'd2; bus.pat_valid = 1'b1;
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b1 || bus.out_bit !== 1'b1 || bus.pat_ready !== 1'b0) begin errors++; $display("FAIL abort_idle_accept got v=%b b=%b r=%b want 1 1 0", bus.out_valid, bus.out_bit, bus.pat_ready); end
        bus.abort = 1'b0; bus.pat_valid = 1'b0;
        for (int i = 0; i < 10 && dseen == 0; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) dseen = i + 1;
        end
        checks++; if (dseen != 2) begin errors++; $display("FAIL abort_idle_done got cycle %0d want 2", dseen); end
    endtask

    task automatic test_reset_mid;
        int vseen;
        int dseen;
        vseen = 0;
        dseen = 0;
        @(negedge clk);
        bus.pat_data = 8'hFF; bus.pat_len = 4'd8; bus.pat_repeat = 4'd1; bus.pat_valid = 1'b1;
        @(negedge clk);
        bus.pat_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.pat_ready !== 1'b1 || bus.out_bit !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL rst_mid got v=%b r=%b b=%b d=%b want 0 1 0 0", bus.out_valid, bus.pat_ready, bus.out_bit, bus.done); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) vseen++;
            if (bus.done !== 1'b0) dseen++;
        end
        checks++; if (vseen != 0 || dseen != 0) begin errors++; $display("FAIL rst_resume got valid=%0d done=%0d want 0 0", vseen, dseen); end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        bus.pat_data = 8'b0000_0110; bus.pat_len = 4'd3; bus.pat_repeat = 4'd0; bus.pat_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            vb[i] = bus.out_valid; ob[i] = bus.out_bit; db[i] = bus.done; rb[i] = bus.pat_ready;
            if (i == 0) bus.pat_data = 8'b0000_0001;
        end
        bus.pat_valid = 1'b0;
        checks++; if ({ob[0], ob[1], ob[2]} !== 3'b110 || {vb[0], vb[1], vb[2]} !== 3'b111) begin errors++; $display("FAIL b2b_first got %b%b%b want 110", ob[0], ob[1], ob[2]); end
        checks++; if ({rb[0], rb[1], rb[2], rb[3], rb[4]} !== 5'b00001) begin errors++; $display("FAIL b2b_spacing got %b%b%b%b%b want 00001", rb[0], rb[1], rb[2], rb[3], rb[4]); end
        checks++; if (db[3] !== 1'b1 || vb[4] !== 1'b0) begin errors++; $display("FAIL b2b_done1 got d=%b v4=%b want 1 0", db[3], vb[4]); end
        checks++; if ({ob[5], ob[6], ob[7]} !== 3'b001 || {vb[5], vb[6], vb[7]} !== 3'b111) begin errors++; $display("FAIL b2b_second got %b%b%b want 001", ob[5], ob[6], ob[7]); end
        checks++; if (db[8] !== 1'b1 || rb[9] !== 1'b1) begin errors++; $display("FAIL b2b_done2 got d=%b r=%b want 1 1", db[8], rb[9]); end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        bus.pat_valid = 1'b0;
        bus.pat_data = '0;
        bus.pat_len = '0;
        bus.pat_repeat = '0;
        bus.abort = 1'b0;
        test_reset();
        test_basic();
        test_repeat();
        test_len0();
        test_clamp();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got no finish want finish");
        $fatal(1, "timeout");
    end
endmodule
